// File: rtl/ble_tx_dma_pkg.sv
// rtl/ble_tx_dma_pkg.sv - state encoding, window defaults and byte/address helpers for the BLE TX DMA
package ble_tx_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_SEND,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    localparam logic [31:0] ADR_LL_DEF      = 32'h00C0_0000;
    localparam logic [31:0] ADR_UL_DEF      = 32'h00C0_FFFC;
    localparam int unsigned ACK_TIMEOUT_DEF = 64;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [31:0] w_sh;
        w_sh = word >> {idx, 3'b000};
        return w_sh[7:0];
    endfunction

    // 33-bit sum so an address near the top of the 32-bit space cannot alias below the window
    function automatic logic [31:0] next_adr(input logic [31:0] adr,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
        logic [32:0] w_sum;
        w_sum = {1'b0, adr} + 33'd4;
        return (w_sum > {1'b0, hi}) ? lo : w_sum[31:0];
    endfunction

endpackage

// File: rtl/ble_tx_dma_if.sv
// rtl/ble_tx_dma_if.sv - arbiter, Wishbone read port and uart_tx handshake bundle
interface ble_tx_dma_if;
    logic        req;
    logic        gnt;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic [7:0]  tx_data;
    logic        tx_active;
    logic        tx_done;

    modport master (
        output req, wb_adr, wb_cyc, wb_we, wb_sel, tx_data, tx_active,
        input  gnt, wb_rdt, wb_ack, tx_done
    );

    modport slave (
        input  req, wb_adr, wb_cyc, wb_we, wb_sel, tx_data, tx_active,
        output gnt, wb_rdt, wb_ack, tx_done
    );
endinterface

// File: rtl/ble_wb_timeout.sv
// rtl/ble_wb_timeout.sv - loadable down-counter watchdog; expiry flags the last enabled cycle
module ble_wb_timeout #(
    parameter int unsigned N = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(N + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(N);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loaded with N on entry, so a count of 1 is the N-th enabled cycle
    assign o_expire = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/ble_tx_dma.sv
// rtl/ble_tx_dma.sv - streams a RAM byte buffer to uart_tx, one 32-bit word read at a time
module ble_tx_dma
    import ble_tx_dma_pkg::*;
#(
    parameter logic [31:0] ADR_LL      = ADR_LL_DEF,
    parameter logic [31:0] ADR_UL      = ADR_UL_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic                i_start,
    input  logic [31:0]         i_base,
    input  logic [15:0]         i_len,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    ble_tx_dma_if.master        bus
);
    state_t      r_state;
    logic [31:0] r_adr;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_req;
    logic        r_cyc;
    logic [31:0] r_wb_adr;
    logic [7:0]  r_tx_data;
    logic        r_tx_active;

    logic        w_tmo_load;
    logic        w_tmo_expire;

    assign w_tmo_load = (r_state == ST_REQ) && bus.gnt && !i_abort;

    ble_wb_timeout #(.N(ACK_TIMEOUT)) u_timeout (
        .clk      (wb_clk),
        .rst_n    (wb_rst_n),
        .i_load   (w_tmo_load),
        .i_clr    (i_abort),
        .i_en     (r_state == ST_READ),
        .o_expire (w_tmo_expire)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state     <= ST_IDLE;
            r_adr       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_req       <= 1'b0;
            r_cyc       <= 1'b0;
            r_wb_adr    <= '0;
            r_tx_data   <= '0;
            r_tx_active <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort wins over every other event in the same cycle
            if ((r_state != ST_IDLE) && i_abort) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_req       <= 1'b0;
                r_cyc       <= 1'b0;
                r_tx_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (i_len != 16'd0) begin
                                r_adr   <= i_base & ~32'h3;
                                r_cnt   <= i_len;
                                r_idx   <= 2'd0;
                                r_err   <= 1'b0;
                                r_busy  <= 1'b1;
                                r_req   <= 1'b1;
                                r_state <= ST_REQ;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (bus.gnt) begin
                            r_cyc    <= 1'b1;
                            r_wb_adr <= r_adr;
                            r_state  <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        if (bus.wb_ack) begin
                            r_word      <= bus.wb_rdt;
                            r_tx_data   <= byte_lane(bus.wb_rdt, r_idx);
                            r_tx_active <= 1'b1;
                            r_req       <= 1'b0;
                            r_cyc       <= 1'b0;
                            r_state     <= ST_SEND;
                        end else if (w_tmo_expire) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_req   <= 1'b0;
                            r_cyc   <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_SEND: begin
                        r_tx_active <= 1'b0;
                        r_state     <= ST_WAIT_TX;
                    end
                    ST_WAIT_TX: begin
                        if (bus.tx_done) begin
                            r_cnt <= r_cnt - 16'd1;
                            r_idx <= r_idx + 2'd1;
                            if (r_cnt == 16'd1) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else if (r_idx == 2'd3) begin
                                r_adr   <= next_adr(r_adr, ADR_LL, ADR_UL);
                                r_req   <= 1'b1;
                                r_state <= ST_REQ;
                            end else begin
                                r_tx_data   <= byte_lane(r_word, r_idx + 2'd1);
                                r_tx_active <= 1'b1;
                                r_state     <= ST_SEND;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign bus.req       = r_req;
    assign bus.wb_cyc    = r_cyc;
    assign bus.wb_adr    = r_wb_adr;
    assign bus.wb_we     = 1'b0;
    assign bus.wb_sel    = 4'hF;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_active = r_tx_active;

endmodule
